// File: rtl/bit_stats_unit_if.sv
// Handshake bundle between a word source, the bit statistics unit and a result consumer.
interface bit_stats_unit_if #(
  parameter int WIDTH = 16
) ();
  localparam int CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CW-1:0]    in_thresh;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_parity;
  logic             out_eq;
  logic             out_ge;
  logic             busy;

  modport master (
    output in_valid, in_data, in_thresh, out_ready,
    input  in_ready, out_valid, out_count, out_parity, out_eq, out_ge, busy
  );

  modport slave (
    input  in_valid, in_data, in_thresh, out_ready,
    output in_ready, out_valid, out_count, out_parity, out_eq, out_ge, busy
  );
endinterface

// File: rtl/bit_stats_unit.sv
// Sequential popcount/parity/threshold unit: captures one word, scans CHUNK bits per
// cycle, then holds the result until the consumer takes it.
module bit_stats_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic             clk,
  input logic             rst,
  bit_stats_unit_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("bit_stats_unit: CHUNK must divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] word_q;
  logic [CW-1:0]    thr_q;
  logic [CW-1:0]    acc_q;
  logic [IW-1:0]    idx_q;
  logic             out_valid_q;
  logic [CW-1:0]    count_q;
  logic             parity_q;
  logic             eq_q;
  logic             ge_q;

  logic [CW-1:0]    chunk_cnt_d;
  logic [CW-1:0]    sum_d;

  function automatic logic [CW-1:0] pop(input logic [CHUNK-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNK; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  // The captured word is shifted down each scan cycle, so the low CHUNK bits are always the next chunk.
  assign chunk_cnt_d = pop(word_q[CHUNK-1:0]);
  assign sum_d       = acc_q + chunk_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      thr_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
      parity_q    <= 1'b0;
      eq_q        <= 1'b0;
      ge_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            word_q  <= bus.in_data;
            thr_q   <= bus.in_thresh;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          acc_q  <= sum_d;
          idx_q  <= idx_q + IW'(1);
          word_q <= word_q >> CHUNK;
          if (idx_q == LAST) begin
            count_q     <= sum_d;
            parity_q    <= sum_d[0];
            eq_q        <= (sum_d == thr_q);
            ge_q        <= (sum_d >= thr_q);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready must be low during reset even though the state already reads IDLE.
  assign bus.in_ready   = (state_q == IDLE) && !rst;
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_count  = count_q;
  assign bus.out_parity = parity_q;
  assign bus.out_eq     = eq_q;
  assign bus.out_ge     = ge_q;
endmodule

// File: tb/tb_bit_stats_unit.sv
// Bench for bit_stats_unit: three configurations (16/4, 4/1, 16/16) checked against a popcount model.
module tb_bit_stats_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_stats_unit_if #(.WIDTH(16)) ifA ();
  bit_stats_unit_if #(.WIDTH(4))  ifB ();
  bit_stats_unit_if #(.WIDTH(16)) ifC ();

  bit_stats_unit #(.WIDTH(16), .CHUNK(4))  dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
  bit_stats_unit #(.WIDTH(4),  .CHUNK(1))  dutB (.clk(clk), .rst(rst), .bus(ifB.slave));
  bit_stats_unit #(.WIDTH(16), .CHUNK(16)) dutC (.clk(clk), .rst(rst), .bus(ifC.slave));

  // A and C share one driver; use_c selects which one the 16-bit tasks talk to.
  logic        use_c = 1'b0;
  logic        drv_valid = 1'b0;
  logic        drv_ready = 1'b0;
  logic [15:0] drv_data = '0;
  logic [4:0]  drv_thr = '0;

  assign ifA.in_valid  = drv_valid & ~use_c;
  assign ifC.in_valid  = drv_valid & use_c;
  assign ifA.in_data   = drv_data;
  assign ifC.in_data   = drv_data;
  assign ifA.in_thresh = drv_thr;
  assign ifC.in_thresh = drv_thr;
  assign ifA.out_ready = drv_ready & ~use_c;
  assign ifC.out_ready = drv_ready & use_c;

  logic       cur_iready, cur_ovalid, cur_par, cur_eq, cur_ge, cur_busy;
  logic [4:0] cur_cnt;
  assign cur_iready = use_c ? ifC.in_ready   : ifA.in_ready;
  assign cur_ovalid = use_c ? ifC.out_valid  : ifA.out_valid;
  assign cur_cnt    = use_c ? ifC.out_count  : ifA.out_count;
  assign cur_par    = use_c ? ifC.out_parity : ifA.out_parity;
  assign cur_eq     = use_c ? ifC.out_eq     : ifA.out_eq;
  assign cur_ge     = use_c ? ifC.out_ge     : ifA.out_ge;
  assign cur_busy   = use_c ? ifC.busy       : ifA.busy;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    int          thr;
    int          cnt;
    bit          par;
    bit          eq;
    bit          ge;
    int          hold;
  } vec_t;

  // One transaction on A or C: accept, scramble inputs, time the result, apply backpressure, hand off.
  task automatic tx16(input logic [15:0] d, input int thr, input int hold, output int lat,
                      output int cnt, output bit par, output bit eq, output bit ge);
    int n = 0;
    while (!cur_iready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_before_accept", cur_iready, 1);
    drv_valid = 1'b1; drv_data = d; drv_thr = 5'(thr);
    @(posedge clk); @(negedge clk);
    drv_valid = 1'b0; drv_data = 16'($urandom); drv_thr = 5'($urandom);
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!cur_ovalid && lat < 50);
    cnt = int'(cur_cnt); par = cur_par; eq = cur_eq; ge = cur_ge;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_out_valid", cur_ovalid, 1);
      chk("hold_count", cur_cnt, cnt);
      chk("hold_flags", {cur_par, cur_eq, cur_ge}, {par, eq, ge});
      chk("hold_in_ready", cur_iready, 0);
      chk("hold_busy", cur_busy, 1);
    end
    drv_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    drv_ready = 1'b0;
    chk("handoff_out_valid", cur_ovalid, 0);
    chk("handoff_in_ready", cur_iready, 1);
    chk("after_handoff_count_kept", cur_cnt, cnt);
  endtask

  task automatic txB(input logic [3:0] d, input int thr, output int lat,
                     output bit par, output bit eq, output bit ge);
    int n = 0;
    while (!ifB.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("B_in_ready", ifB.in_ready, 1);
    ifB.in_valid = 1'b1; ifB.in_data = d; ifB.in_thresh = 3'(thr);
    @(posedge clk); @(negedge clk);
    ifB.in_valid = 1'b0; ifB.in_data = 4'($urandom); ifB.in_thresh = 3'($urandom);
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!ifB.out_valid && lat < 50);
    par = ifB.out_parity; eq = ifB.out_eq; ge = ifB.out_ge;
    @(posedge clk); @(negedge clk);
  endtask

  vec_t vecs[5];

  initial begin
    int lat, cnt;
    bit par, eq, ge;
    logic [15:0] EQ2, GE3, d;
    int thr, ec;

    vecs[0] = '{16'h0000,  0,  0, 1'b0, 1'b1, 1'b1,  0};
    vecs[1] = '{16'hFFFF, 16, 16, 1'b0, 1'b1, 1'b1, 10};
    vecs[2] = '{16'h8421,  3,  4, 1'b0, 1'b0, 1'b1,  0};
    vecs[3] = '{16'h0007,  4,  3, 1'b1, 1'b0, 1'b0,  2};
    vecs[4] = '{16'h0001, 17,  1, 1'b1, 1'b0, 1'b0,  0};
    EQ2 = 16'h1668;
    GE3 = 16'hE880;

    ifB.in_valid = 1'b0; ifB.in_data = '0; ifB.in_thresh = '0; ifB.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", ifA.in_ready, 0);
    chk("rst_out_valid", ifA.out_valid, 0);
    chk("rst_fields", {ifA.out_count, ifA.out_parity, ifA.out_eq, ifA.out_ge}, 0);
    chk("rst_busy", ifA.busy, 0);
    rst = 1'b0;
    #1;
    chk("release_in_ready", ifA.in_ready, 1);

    // Directed vectors on 16/4
    for (int i = 0; i < 5; i++) begin
      tx16(vecs[i].d, vecs[i].thr, vecs[i].hold, lat, cnt, par, eq, ge);
      chk($sformatf("A_vec%0d_latency", i), lat, 4);
      chk($sformatf("A_vec%0d_count", i), cnt, vecs[i].cnt);
      chk($sformatf("A_vec%0d_parity", i), par, vecs[i].par);
      chk($sformatf("A_vec%0d_eq", i), eq, vecs[i].eq);
      chk($sformatf("A_vec%0d_ge", i), ge, vecs[i].ge);
    end

    // Reset mid-scan discards the word
    @(negedge clk);
    drv_valid = 1'b1; drv_data = 16'h00FF; drv_thr = 5'd8;
    @(posedge clk); @(negedge clk);
    drv_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", ifA.out_valid, 0);
    chk("midrst_fields", {ifA.out_count, ifA.out_parity, ifA.out_eq, ifA.out_ge}, 0);
    chk("midrst_in_ready", ifA.in_ready, 0);
    chk("midrst_busy", ifA.busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_release_in_ready", ifA.in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midrst_no_pulse", ifA.out_valid, 0);
    end
    tx16(16'h0003, 2, 0, lat, cnt, par, eq, ge);
    chk("postrst_count", cnt, 2);
    chk("postrst_eq", eq, 1);

    // Random words on 16/4 with random backpressure
    for (int i = 0; i < 25; i++) begin
      d = 16'($urandom);
      thr = $urandom_range(0, 20);
      ec = $countones(d);
      tx16(d, thr, $urandom_range(0, 3), lat, cnt, par, eq, ge);
      chk("A_rand_latency", lat, 4);
      chk("A_rand_count", cnt, ec);
      chk("A_rand_parity", par, ec % 2);
      chk("A_rand_eq", eq, int'(ec == thr));
      chk("A_rand_ge", ge, int'(ec >= thr));
    end

    // 4/1 breadboard sweep: parity, exactly-two, at-least-three
    for (int i = 0; i < 16; i++) begin
      d = 16'(i);
      txB(d[3:0], 2, lat, par, eq, ge);
      chk($sformatf("B_%0d_latency", i), lat, 4);
      chk($sformatf("B_%0d_parity", i), par, ^d[3:0]);
      chk($sformatf("B_%0d_exactly2", i), eq, EQ2[i]);
      txB(d[3:0], 3, lat, par, eq, ge);
      chk($sformatf("B_%0d_atleast3", i), ge, GE3[i]);
    end

    // 16/16 single-cycle scan
    use_c = 1'b1;
    @(negedge clk);
    tx16(16'hAAAA, 8, 1, lat, cnt, par, eq, ge);
    chk("C_latency", lat, 1);
    chk("C_AAAA_count", cnt, 8);
    chk("C_AAAA_parity", par, 0);
    chk("C_AAAA_eq_ge", {eq, ge}, 2'b11);
    for (int i = 0; i < 10; i++) begin
      d = 16'($urandom);
      thr = $urandom_range(0, 31);
      ec = $countones(d);
      tx16(d, thr, 0, lat, cnt, par, eq, ge);
      chk("C_rand_latency", lat, 1);
      chk("C_rand_count", cnt, ec);
      chk("C_rand_flags", {par, eq, ge}, {ec % 2 == 1, ec == thr, ec >= thr});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
